snn_lane_core: RTL and testbench

//  Next-generation SNN neuron-update engine: LANES leaky integrate-and-fire neurons updated per cycle.

---
 rtl/snn_lane_pkg.sv | 19 +
 rtl/snn_lane_core_mfifo.sv | 49 ++++
 rtl/snn_lane_core.sv | 130 +++++++++++++
 tb/tb_snn_lane_core.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/snn_lane_pkg.sv
// snn_lane_pkg: core state encoding, default geometry and saturating LIF arithmetic shared by the lane core.
package snn_lane_pkg;
  typedef enum logic [1:0] {IDLE, UPDATE, DONE} core_state_e;
  localparam int NEURON_COUNT_DEF = 256;
  localparam int LANES_DEF = 4;
  localparam int GROUPS = NEURON_COUNT_DEF / LANES_DEF;
  function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    return x > hi ? hi : x < -hi - 32'sd1 ? -hi - 32'sd1 : x;
  endfunction
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a, input logic signed [31:0] b, input int w);
    return sat(a + b, w);
  endfunction
  function automatic logic signed [31:0] lif_update(input logic signed [31:0] v, input logic signed [31:0] cur,
                                                    input int shift, input int vw);
    return sat(v - (v >>> shift) + cur, vw);
  endfunction
endpackage

// File: rtl/snn_lane_core_mfifo.sv
// snn_spike_mfifo: FWFT FIFO accepting up to LANES pushes per cycle in lane order, one pop per cycle.
module snn_spike_mfifo #(
  parameter int LANES = 4,
  parameter int DEPTH = 16,
  parameter int AW = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [LANES-1:0]             push,
  input  logic [LANES*AW-1:0]          data,
  input  logic                         pop_ready,
  output logic                         valid,
  output logic [AW-1:0]                head,
  output logic [$clog2(DEPTH+1)-1:0]   free
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(DEPTH + 1);
  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wr, rd;
  logic [FW-1:0] cnt, npush;
  logic [PW-1:0] widx [LANES];
  logic pop;
  assign valid = cnt != '0;
  assign pop = valid && pop_ready;
  assign head = valid ? mem[rd] : '0;
  assign free = FW'(DEPTH) - cnt;
  // Pushed lanes are packed densely so lower lanes land nearer the head.
  always_comb begin
    npush = '0;
    for (int k = 0; k < LANES; k++) begin
      widx[k] = PW'((int'(wr) + int'(npush)) % DEPTH);
      npush = npush + FW'(push[k]);
    end
  end
  always_ff @(posedge clk)
    for (int k = 0; k < LANES; k++)
      if (push[k]) mem[widx[k]] <= data[k*AW +: AW];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr <= '0;
      rd <= '0;
      cnt <= '0;
    end else begin
      wr <= PW'((int'(wr) + int'(npush)) % DEPTH);
      rd <= pop ? (rd == PW'(DEPTH - 1) ? '0 : rd + 1'b1) : rd;
      cnt <= cnt + npush - FW'(pop);
    end
  end
endmodule

// File: rtl/snn_lane_core.sv
// snn_lane_core: LIF neuron engine integrating synaptic events, sweeping LANES neurons per cycle into a spike FIFO.
// Define SNN_LANE_SPIKE_COUNT_EN to add the o_step_spike_count output.
module snn_lane_core
  import snn_lane_pkg::*;
#(
  parameter int NEURON_COUNT = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int LANES = 4,
  parameter int V_WIDTH = 16,
  parameter int W_WIDTH = 8,
  parameter int CUR_WIDTH = 16,
  parameter int LEAK_SHIFT = 4,
  parameter int REFRAC_WIDTH = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_syn_valid,
  output logic                    o_syn_ready,
  input  logic [ADDR_WIDTH-1:0]   i_syn_addr,
  input  logic [W_WIDTH-1:0]      i_syn_weight,
  input  logic                    i_step_start,
  input  logic [V_WIDTH-1:0]      i_threshold,
  input  logic [V_WIDTH-1:0]      i_v_reset,
  input  logic [REFRAC_WIDTH-1:0] i_refrac_cycles,
  output logic                    o_busy,
  output logic                    o_step_done,
  output logic                    o_spike_valid,
  input  logic                    i_spike_ready,
  output logic [ADDR_WIDTH-1:0]   o_spike_addr
`ifdef SNN_LANE_SPIKE_COUNT_EN
  ,
  output logic [ADDR_WIDTH:0]     o_step_spike_count
`endif
);
  localparam int G = NEURON_COUNT / LANES;
  localparam int GW = G > 1 ? $clog2(G) : 1;
  localparam int NW = NEURON_COUNT > 1 ? $clog2(NEURON_COUNT) : 1;
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  core_state_e state, state_n;
  logic [GW-1:0] grp;
  logic signed [V_WIDTH-1:0] v [NEURON_COUNT];
  logic signed [CUR_WIDTH-1:0] cur [NEURON_COUNT];
  logic [REFRAC_WIDTH-1:0] rf [NEURON_COUNT];
  logic signed [V_WIDTH-1:0] thr, vres;
  logic [REFRAC_WIDTH-1:0] rfc;
  logic [NW-1:0] nid [LANES];
  logic signed [31:0] vn [LANES];
  logic signed [V_WIDTH-1:0] v_n [LANES];
  logic [REFRAC_WIDTH-1:0] rf_n [LANES];
  logic [LANES-1:0] spk;
  logic [LANES*ADDR_WIDTH-1:0] lane_addr;
  logic [FW-1:0] free;
  logic syn_fire, start, adv, last;
  assign o_syn_ready = state == IDLE;
  assign o_busy = state != IDLE;
  assign o_step_done = state == DONE;
  assign syn_fire = i_syn_valid && o_syn_ready;
  assign start = o_syn_ready && i_step_start;
  // A group only advances when the FIFO can absorb a spike from every lane.
  assign adv = state == UPDATE && free >= FW'(LANES);
  assign last = grp == GW'(G - 1);
  always_comb
    state_n = state == IDLE ? (i_step_start ? UPDATE : IDLE) :
              state == UPDATE ? (adv && last ? DONE : UPDATE) : IDLE;
  always_comb begin
    spk = '0;
    lane_addr = '0;
    for (int l = 0; l < LANES; l++) begin
      nid[l] = NW'(int'(grp) * LANES + l);
      vn[l] = lif_update(32'(v[nid[l]]), 32'(cur[nid[l]]), LEAK_SHIFT, V_WIDTH);
      spk[l] = rf[nid[l]] == '0 && vn[l] >= 32'(thr);
      v_n[l] = rf[nid[l]] != '0 || spk[l] ? vres : V_WIDTH'(vn[l]);
      rf_n[l] = rf[nid[l]] != '0 ? rf[nid[l]] - 1'b1 : spk[l] ? rfc : '0;
      lane_addr[l*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(nid[l]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      grp <= '0;
      thr <= '0;
      vres <= '0;
      rfc <= '0;
      for (int n = 0; n < NEURON_COUNT; n++) begin
        v[n] <= '0;
        cur[n] <= '0;
        rf[n] <= '0;
      end
    end else begin
      state <= state_n;
      if (syn_fire && 32'(i_syn_addr) < NEURON_COUNT)
        cur[NW'(i_syn_addr)] <= CUR_WIDTH'(sat_add(32'(cur[NW'(i_syn_addr)]), 32'($signed(i_syn_weight)), CUR_WIDTH));
      if (start) begin
        thr <= i_threshold;
        vres <= i_v_reset;
        rfc <= i_refrac_cycles;
        grp <= '0;
      end
      if (adv) begin
        for (int l = 0; l < LANES; l++) begin
          v[nid[l]] <= v_n[l];
          cur[nid[l]] <= '0;
          rf[nid[l]] <= rf_n[l];
        end
        grp <= last ? '0 : grp + 1'b1;
      end
    end
  end
  snn_spike_mfifo #(.LANES(LANES), .DEPTH(FIFO_DEPTH), .AW(ADDR_WIDTH)) fifo (
    .clk(clk),
    .rst(rst),
    .push(spk & {LANES{adv}}),
    .data(lane_addr),
    .pop_ready(i_spike_ready),
    .valid(o_spike_valid),
    .head(o_spike_addr),
    .free(free)
  );
`ifdef SNN_LANE_SPIKE_COUNT_EN
  localparam int CW = ADDR_WIDTH + 1;
  logic [CW-1:0] scnt;
  always_ff @(posedge clk) begin
    if (rst) scnt <= '0;
    else if (start) scnt <= '0;
    else if (adv) scnt <= scnt + CW'($countones(spk));
  end
  assign o_step_spike_count = scnt;
`endif
endmodule

// File: tb/tb_snn_lane_core.sv
// tb_snn_lane_core: directed and randomized checks of snn_lane_core against an integer LIF reference model.
module tb_snn_lane_core;
  localparam int N = 256;
  localparam int G = 64;
  logic clk = 1'b0;
  logic rst, i_syn_valid, o_syn_ready, i_step_start, o_busy, o_step_done, o_spike_valid, i_spike_ready;
  logic [7:0] i_syn_addr, i_syn_weight, o_spike_addr;
  logic [15:0] i_threshold, i_v_reset;
  logic [3:0] i_refrac_cycles;
  int total = 0;
  int bad = 0;
  int mv [N];
  int mc [N];
  int mr [N];
  int exp_q [$];
  int got_q [$];
  always #5 clk = ~clk;
  snn_lane_core dut (
    .clk(clk), .rst(rst),
    .i_syn_valid(i_syn_valid), .o_syn_ready(o_syn_ready),
    .i_syn_addr(i_syn_addr), .i_syn_weight(i_syn_weight),
    .i_step_start(i_step_start), .i_threshold(i_threshold),
    .i_v_reset(i_v_reset), .i_refrac_cycles(i_refrac_cycles),
    .o_busy(o_busy), .o_step_done(o_step_done),
    .o_spike_valid(o_spike_valid), .i_spike_ready(i_spike_ready),
    .o_spike_addr(o_spike_addr)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int obs, input int expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask
  function automatic int clampw(input int x, input int w);
    int hi;
    hi = (1 << (w - 1)) - 1;
    return x > hi ? hi : x < -hi - 1 ? -hi - 1 : x;
  endfunction
  task automatic model_reset();
    for (int n = 0; n < N; n++) begin
      mv[n] = 0;
      mc[n] = 0;
      mr[n] = 0;
    end
  endtask
  task automatic model_event(input int a, input int w);
    if (a < N) mc[a] = clampw(mc[a] + w, 16);
  endtask
  task automatic model_step(input int thr, input int vres, input int rfc);
    int vn;
    exp_q.delete();
    for (int n = 0; n < N; n++) begin
      if (mr[n] > 0) begin
        mv[n] = vres;
        mr[n]--;
      end else begin
        vn = clampw(mv[n] - (mv[n] >>> 4) + mc[n], 16);
        if (vn >= thr) begin
          exp_q.push_back(n);
          mv[n] = vres;
          mr[n] = rfc;
        end else mv[n] = vn;
      end
      mc[n] = 0;
    end
  endtask
  task automatic send_event(input int a, input int w);
    i_syn_valid = 1'b1;
    i_syn_addr = 8'(a);
    i_syn_weight = 8'(w);
    tick();
    i_syn_valid = 1'b0;
    model_event(a, w);
  endtask
  // mode 0: consumer always ready, 1: random ready, 2: ready withheld for hold cycles
  task automatic run_step(input int thr, input int vres, input int rfc, input int mode, input int hold,
                          input int ev_a, input int ev_w, output int cyc);
    int ok;
    if (ev_a >= 0) begin
      i_syn_valid = 1'b1;
      i_syn_addr = 8'(ev_a);
      i_syn_weight = 8'(ev_w);
      model_event(ev_a, ev_w);
    end
    model_step(thr, vres, rfc);
    got_q.delete();
    i_threshold = 16'(thr);
    i_v_reset = 16'(vres);
    i_refrac_cycles = 4'(rfc);
    i_step_start = 1'b1;
    tick();
    i_step_start = 1'b0;
    i_syn_valid = 1'b0;
    cyc = -1;
    for (int k = 1; k <= 4000 && cyc < 0; k++) begin
      i_spike_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'(k > hold);
      if (mode == 2 && k == hold) begin
        chk("bp_busy", int'(o_busy), 1);
        chk("bp_head", int'(o_spike_addr), 0);
        chk("bp_fifo_full", int'(dut.fifo.cnt), 16);
        chk("bp_stall_lo", int'(dut.cur[15]), 0);
        chk("bp_stall_hi", int'(dut.cur[16]), 120);
      end
      if (o_spike_valid && i_spike_ready) got_q.push_back(int'(o_spike_addr));
      tick();
      if (o_step_done) cyc = k;
    end
    chk("done_seen", int'(cyc > 0), 1);
    i_spike_ready = 1'b1;
    if (o_spike_valid) got_q.push_back(int'(o_spike_addr));
    tick();
    chk("done_pulse", int'({o_step_done, o_busy}), 0);
    for (int k = 0; k < 300 && o_spike_valid; k++) begin
      got_q.push_back(int'(o_spike_addr));
      tick();
    end
    chk("spike_count", got_q.size(), exp_q.size());
    ok = got_q.size() == exp_q.size() ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] != exp_q[i]) ok = 0;
    chk("spike_order", ok, 1);
  endtask
  initial begin
    int cyc, pat, nev, a, seen;
    rst = 1'b1;
    i_syn_valid = 1'b0;
    i_syn_addr = '0;
    i_syn_weight = '0;
    i_step_start = 1'b0;
    i_threshold = '0;
    i_v_reset = '0;
    i_refrac_cycles = '0;
    i_spike_ready = 1'b0;
    model_reset();
    tick();
    tick();
    rst = 1'b0;
    chk("rst_syn_ready", int'(o_syn_ready), 1);
    chk("rst_busy", int'(o_busy), 0);
    chk("rst_done", int'(o_step_done), 0);
    chk("rst_spike_valid", int'(o_spike_valid), 0);
    chk("rst_spike_addr", int'(o_spike_addr), 0);
    send_event(5, 120);
    run_step(100, 0, 0, 0, 0, -1, 0, cyc);
    chk("fire_latency", cyc, G);
    chk("fire_first", got_q.size() > 0 ? got_q[0] : -1, 5);
    chk("fire_v5", int'(dut.v[5]), 0);
    send_event(9, 50);
    run_step(100, 0, 0, 0, 0, -1, 0, cyc);
    chk("leak_v50", int'(dut.v[9]), 50);
    run_step(100, 0, 0, 0, 0, -1, 0, cyc);
    chk("leak_v47", int'(dut.v[9]), 47);
    pat = 0;
    for (int s = 0; s < 4; s++) begin
      send_event(3, 120);
      run_step(100, 0, 2, 0, 0, -1, 0, cyc);
      pat = pat * 10 + got_q.size();
    end
    chk("refrac_pattern", pat, 1001);
    for (int i = 0; i < 260; i++) send_event(0, 127);
    chk("sat_hi", int'(dut.cur[0]), 32767);
    for (int i = 0; i < 260; i++) send_event(1, -128);
    chk("sat_lo", int'(dut.cur[1]), -32768);
    run_step(100, 0, 0, 0, 0, -1, 0, cyc);
    chk("sat_spike", got_q.size() > 0 ? got_q[0] : -1, 0);
    chk("sat_v1", int'(dut.v[1]), -32768);
    run_step(100, 0, 0, 0, 0, -1, 0, cyc);
    chk("leak_neg", int'(dut.v[1]), -30720);
    run_step(100, 0, 0, 0, 0, 7, 120, cyc);
    chk("simul_event", got_q.size() > 0 ? got_q[0] : -1, 7);
    for (int s = 0; s < 6; s++) begin
      nev = $urandom_range(10, 60);
      for (int i = 0; i < nev; i++) send_event($urandom_range(0, 255), $urandom_range(0, 255) - 128);
      run_step($urandom_range(20, 300), $urandom_range(0, 40) - 20, $urandom_range(0, 3), 1, 0, -1, 0, cyc);
      for (int i = 0; i < 3; i++) begin
        a = $urandom_range(0, 255);
        chk("rand_v", int'(dut.v[a]), mv[a]);
      end
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    for (int n = 0; n < N; n++) send_event(n, 120);
    run_step(100, 0, 0, 2, 40, -1, 0, cyc);
    chk("bp_done_delayed", int'(cyc > G), 1);
    send_event(200, 120);
    send_event(20, 120);
    i_threshold = 16'd100;
    i_v_reset = '0;
    i_refrac_cycles = '0;
    i_spike_ready = 1'b0;
    i_step_start = 1'b1;
    tick();
    i_step_start = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("mid_busy", int'(o_busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_reset();
    chk("mid_rst_busy", int'(o_busy), 0);
    chk("mid_rst_fifo", int'(o_spike_valid), 0);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      if (o_step_done) seen = 1;
      tick();
    end
    chk("mid_rst_no_done", seen, 0);
    send_event(5, 120);
    run_step(100, 0, 0, 0, 0, -1, 0, cyc);
    chk("post_rst_only5", got_q.size() == 1 ? got_q[0] : -1, 5);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
